// File: rtl/ehl_tap_pkg.sv
// ehl_tap_pkg: TAP controller state encodings and instruction code helpers.
// Shared by ehl_tap_fsm and ehl_tap_mc.
package ehl_tap_pkg;

    // 4-bit TAP state encoding. All 16 codes are used.
    localparam logic [3:0] ST_TLR      = 4'hF;
    localparam logic [3:0] ST_RTI      = 4'hC;
    localparam logic [3:0] ST_SEL_DR   = 4'h7;
    localparam logic [3:0] ST_CAP_DR   = 4'h6;
    localparam logic [3:0] ST_SH_DR    = 4'h2;
    localparam logic [3:0] ST_EX1_DR   = 4'h1;
    localparam logic [3:0] ST_PAUSE_DR = 4'h3;
    localparam logic [3:0] ST_EX2_DR   = 4'h0;
    localparam logic [3:0] ST_UPD_DR   = 4'h5;
    localparam logic [3:0] ST_SEL_IR   = 4'h4;
    localparam logic [3:0] ST_CAP_IR   = 4'hE;
    localparam logic [3:0] ST_SH_IR    = 4'hA;
    localparam logic [3:0] ST_EX1_IR   = 4'h9;
    localparam logic [3:0] ST_PAUSE_IR = 4'hB;
    localparam logic [3:0] ST_EX2_IR   = 4'h8;
    localparam logic [3:0] ST_UPD_IR   = 4'hD;

    // Instruction codes as a function of the IR width.
    function automatic int unsigned bypass_code(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned usercode_code(input int unsigned w);
        return (32'd1 << w) - 32'd2;
    endfunction

    function automatic int unsigned idcode_code(input int unsigned w);
        return (w > 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic int unsigned tdr_base_code(input int unsigned w);
        return (w > 0) ? 32'd2 : 32'd0;
    endfunction

endpackage

// File: rtl/ehl_tap_fsm.sv
// ehl_tap_fsm: 16-state JTAG TAP controller state register and decodes.
module ehl_tap_fsm
    import ehl_tap_pkg::*;
(
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic shift_dr,
    output logic shift_ir,
    output logic capture_dr,
    output logic capture_ir,
    output logic update_dr,
    output logic update_ir,
    output logic reset_state,
    output logic run_idle
);

    logic [3:0] state_q, state_d;

    // Next-state logic following the standard TAP diagram.
    always_comb begin
        state_d = ST_TLR;
        case (state_q)
            ST_TLR:      state_d = tms ? ST_TLR    : ST_RTI;
            ST_RTI:      state_d = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   state_d = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   state_d = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    state_d = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   state_d = tms ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = tms ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   state_d = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   state_d = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   state_d = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   state_d = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    state_d = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   state_d = tms ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = tms ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   state_d = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   state_d = tms ? ST_SEL_DR : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    // State register; trst forces Test-Logic-Reset.
    always_ff @(posedge tck) begin
        if (trst) state_q <= ST_TLR;
        else      state_q <= state_d;
    end

    assign shift_dr    = (state_q == ST_SH_DR);
    assign shift_ir    = (state_q == ST_SH_IR);
    assign capture_dr  = (state_q == ST_CAP_DR);
    assign capture_ir  = (state_q == ST_CAP_IR);
    assign update_dr   = (state_q == ST_UPD_DR);
    assign update_ir   = (state_q == ST_UPD_IR);
    assign reset_state = (state_q == ST_TLR);
    assign run_idle    = (state_q == ST_RTI);

endmodule

// File: rtl/ehl_tap_mc.sv
// ehl_tap_mc: JTAG TAP with IR, BYPASS, optional IDCODE and external TDR
// channels. Define EHL_TAP_USERCODE_EN to add the USERCODE data register.
module ehl_tap_mc
    import ehl_tap_pkg::*;
#(
    parameter int unsigned IR_WIDTH = 4,
    parameter int unsigned TDR_CNT  = 2,
    parameter logic [31:0] ID       = 32'h0,
    parameter logic [31:0] USERCODE = 32'h0
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                shift_dr,
    output logic                capture_dr,
    output logic                update_dr,
    output logic                reset_state,
    output logic                run_idle,
    output logic [TDR_CNT-1:0]  tdr_sel,
    input  logic [TDR_CNT-1:0]  tdr_in,
    output logic [IR_WIDTH-1:0] instruction
);

    localparam logic                HAS_ID   = ID[0];
    localparam logic [IR_WIDTH-1:0] C_BYPASS = IR_WIDTH'(bypass_code(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] C_IDCODE = IR_WIDTH'(idcode_code(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] C_RESET  = HAS_ID ? C_IDCODE : C_BYPASS;
    localparam logic [IR_WIDTH-1:0] IR_CAP   = IR_WIDTH'(2'b01);

    // A non-zero ID without the presence bit is a configuration error.
    if (!ID[0] && (ID[31:1] != 31'h0)) begin : g_bad_id
        $fatal(1, "ehl_tap_mc: ID[0]=0 with non-zero ID[31:1]");
    end

    logic shift_ir, capture_ir, update_ir;

    ehl_tap_fsm u_fsm (
        .tck         (tck),
        .trst        (trst),
        .tms         (tms),
        .shift_dr    (shift_dr),
        .shift_ir    (shift_ir),
        .capture_dr  (capture_dr),
        .capture_ir  (capture_ir),
        .update_dr   (update_dr),
        .update_ir   (update_ir),
        .reset_state (reset_state),
        .run_idle    (run_idle)
    );

    logic [IR_WIDTH-1:0] ir_sr_q, instr_q;
    logic                bypass_q, tdo_q, tdo_en_q, dr_bit;
    logic [31:0]         id_sr_q;
    logic                id_sel;

    assign id_sel = HAS_ID && (instr_q == C_IDCODE);

    // One-hot TDR select decoded straight from the instruction.
    for (genvar k = 0; k < TDR_CNT; k++) begin : g_sel
        assign tdr_sel[k] = (instr_q == IR_WIDTH'(tdr_base_code(IR_WIDTH) + k));
    end

    // IR shift register: capture 01 pattern, shift tdi in at the MSB.
    always_ff @(posedge tck) begin
        if (trst)            ir_sr_q <= IR_CAP;
        else if (capture_ir) ir_sr_q <= IR_CAP;
        else if (shift_ir)   ir_sr_q <= {tdi, ir_sr_q[IR_WIDTH-1:1]};
    end

    // Active instruction, updated on the falling edge.
    always_ff @(negedge tck) begin
        if (trst || reset_state) instr_q <= C_RESET;
        else if (update_ir)      instr_q <= ir_sr_q;
    end

    // Bypass bit; it is also the fallback for every unmapped code.
    always_ff @(posedge tck) begin
        if (trst)            bypass_q <= 1'b0;
        else if (capture_dr) bypass_q <= 1'b0;
        else if (shift_dr)   bypass_q <= tdi;
    end

    // IDCODE shift register, only moves while IDCODE is selected.
    always_ff @(posedge tck) begin
        if (trst)                      id_sr_q <= '0;
        else if (id_sel && capture_dr) id_sr_q <= ID;
        else if (id_sel && shift_dr)   id_sr_q <= {tdi, id_sr_q[31:1]};
    end

`ifdef EHL_TAP_USERCODE_EN
    localparam logic [IR_WIDTH-1:0] C_USER = IR_WIDTH'(usercode_code(IR_WIDTH));
    logic        uc_sel;
    logic [31:0] uc_sr_q;
    assign uc_sel = (instr_q == C_USER);

    // USERCODE shift register, same shifting as IDCODE.
    always_ff @(posedge tck) begin
        if (trst)                      uc_sr_q <= '0;
        else if (uc_sel && capture_dr) uc_sr_q <= USERCODE;
        else if (uc_sel && shift_dr)   uc_sr_q <= {tdi, uc_sr_q[31:1]};
    end
`endif

    // Data-register serial output chosen by the active instruction.
    always_comb begin
        dr_bit = bypass_q;
        if (id_sel) dr_bit = id_sr_q[0];
`ifdef EHL_TAP_USERCODE_EN
        if (uc_sel) dr_bit = uc_sr_q[0];
`endif
        for (int k = 0; k < TDR_CNT; k++)
            if (tdr_sel[k]) dr_bit = tdr_in[k];
    end

    // tdo and its enable launch on the falling edge; tdo holds outside shifts.
    always_ff @(negedge tck) begin
        if (trst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= shift_ir | shift_dr;
            if (shift_ir)      tdo_q <= ir_sr_q[0];
            else if (shift_dr) tdo_q <= dr_bit;
        end
    end

    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_ehl_tap_mc.sv
// tb_ehl_tap_mc: directed vectors for ehl_tap_mc (IR_WIDTH=4, TDR_CNT=2).
module tb_ehl_tap_mc;

    localparam logic [31:0] TB_ID = 32'h1234_5677;
    localparam logic [31:0] TB_UC = 32'hCAFE_0001;

    logic       tck = 1'b0;
    logic       trst, tms, tdi;
    logic       tdo, tdo_en, shift_dr, capture_dr, update_dr, reset_state, run_idle;
    logic [1:0] tdr_sel, tdr_in;
    logic [3:0] instruction;

    int vecs = 0;
    int errs = 0;

    ehl_tap_mc #(.IR_WIDTH(4), .TDR_CNT(2), .ID(TB_ID), .USERCODE(TB_UC)) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .shift_dr(shift_dr), .capture_dr(capture_dr), .update_dr(update_dr),
        .reset_state(reset_state), .run_idle(run_idle), .tdr_sel(tdr_sel),
        .tdr_in(tdr_in), .instruction(instruction)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCK cycle; outputs are stable 1 time unit after the falling edge.
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Starting in a Shift state: collect n tdo bits, leave to Exit1 on the last.
    task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic ir_scan(input logic [3:0] v, output logic [31:0] cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift_bits(4, {28'h0, v}, cap);
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        step(1, 0); step(0, 0); step(0, 0);
        shift_bits(n, din, dout);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        logic [31:0] d, d2;
        trst = 1'b1; tms = 1'b1; tdi = 1'b0; tdr_in = 2'b00;

        // reset
        step(1, 0);
        trst = 1'b0;
        check("rst_state", 32'(reset_state), 32'h1);
        check("rst_instr", 32'(instruction), 32'h1);
        check("rst_tdo_en", 32'(tdo_en), 32'h0);
        check("rst_tdo", 32'(tdo), 32'h0);
        check("rst_tdr_sel", 32'(tdr_sel), 32'h0);
        step(0, 0);
        check("rti", 32'(run_idle), 32'h1);
        dr_scan(32, 32'h0, d);
        check("idcode", d, TB_ID);

        // five tms=1 from Shift-DR is the worst case path to reset
        step(1, 0); step(0, 0); step(0, 0);
        check("in_shift_dr", 32'(shift_dr), 32'h1);
        check("shift_tdo_en", 32'(tdo_en), 32'h1);
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        check("tms4_not_rst", 32'(reset_state), 32'h0);
        step(1, 0);
        check("tms5_rst", 32'(reset_state), 32'h1);
        step(0, 0);
        check("tms5_rti", 32'(run_idle), 32'h1);

        // TDR 1
        ir_scan(4'h3, d);
        check("ir_capture", d, 32'h1);
        check("ir3_instr", 32'(instruction), 32'h3);
        check("ir3_sel", 32'(tdr_sel), 32'h2);
        tdr_in = 2'b10;
        dr_scan(4, 32'h0, d);
        check("tdr1_hi", d, 32'hF);
        tdr_in = 2'b01;
        dr_scan(4, 32'hF, d);
        check("tdr1_lo", d, 32'h0);

        // TDR 0
        ir_scan(4'h2, d);
        check("ir2_sel", 32'(tdr_sel), 32'h1);
        dr_scan(4, 32'h0, d);
        check("tdr0_hi", d, 32'hF);

        // BYPASS
        ir_scan(4'hF, d);
        check("byp_sel", 32'(tdr_sel), 32'h0);
        dr_scan(3, 32'b101, d);
        check("bypass", d, 32'b010);

        // unmapped code acts as bypass
        ir_scan(4'h9, d);
        check("ir9_sel", 32'(tdr_sel), 32'h0);
        dr_scan(4, 32'b1101, d);
        check("ir9_bypass", d, 32'b1010);

        // USERCODE code
        ir_scan(4'hE, d);
`ifdef EHL_TAP_USERCODE_EN
        dr_scan(32, 32'h0, d);
        check("usercode", d, TB_UC);
`else
        dr_scan(3, 32'b101, d);
        check("uc_bypass", d, 32'b010);
`endif

        // paused IDCODE scan resumes without recapture
        trst = 1'b1; step(1, 0); trst = 1'b0;
        step(0, 0);
        step(1, 0); step(0, 0); step(0, 0);
        shift_bits(16, 32'h0, d);
        step(0, 0); step(0, 0);
        check("pause_tdo_en", 32'(tdo_en), 32'h0);
        step(1, 0); step(0, 0);
        shift_bits(16, 32'h0, d2);
        step(1, 0); step(0, 0);
        check("pause_id", {d2[15:0], d[15:0]}, TB_ID);

        // trst mid-scan
        ir_scan(4'h3, d);
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1);
        check("mid_tdo_en", 32'(tdo_en), 32'h1);
        trst = 1'b1; step(0, 1); trst = 1'b0;
        check("mid_rst_state", 32'(reset_state), 32'h1);
        check("mid_rst_instr", 32'(instruction), 32'h1);
        check("mid_rst_tdo_en", 32'(tdo_en), 32'h0);
        check("mid_rst_tdo", 32'(tdo), 32'h0);
        check("mid_rst_sel", 32'(tdr_sel), 32'h0);
        step(0, 0);
        dr_scan(32, 32'h0, d);
        check("post_rst_id", d, TB_ID);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
